lru_victim_select: RTL and testbench

- Eviction-side counterpart of the cache's per-set LRU hit-update logic.
- Owns the LRU state array for a 4-way set-associative cache and absorbs hit promotions from the lookup pipeline.
- On a miss, picks the replacement way for the requested set: an invalid way if one exists, otherwise the LRU way.
- Promotes the chosen way to MRU when the miss handler accepts the victim.

---
 rtl/lru_pkg.sv | 40 ++++
 rtl/lru_victim_pick.sv | 43 ++++
 rtl/lru_victim_select.sv | 119 +++++++++++
 tb/tb_lru_victim_select.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// Shared constants, FSM state type and the rank-promotion helper for the
// 4-way LRU victim selector.
package lru_pkg;

  localparam int          WAYS      = 4;
  localparam logic [3:0]  RANK_MRU  = 4'b1000;
  localparam logic [3:0]  RANK_LRU  = 4'b0001;
  localparam logic [15:0] LRU_RESET = 16'h8421;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } fsm_state_e;

  // Move the selected way to MRU; ways more recent than it age by one rank,
  // less recent ways keep their rank. Non-one-hot selects fall back to way0.
  function automatic logic [15:0] lru_promote(input logic [15:0] state,
                                              input logic [3:0]  way);
    logic [1:0]  idx;
    logic [3:0]  r;
    logic [3:0]  f;
    logic [15:0] res;
    case (way)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    r   = state[{idx, 2'b00} +: 4];
    res = state;
    for (int i = 0; i < WAYS; i++) begin
      f = state[4*i +: 4];
      if (f == r)      res[4*i +: 4] = RANK_MRU;
      else if (f > r)  res[4*i +: 4] = f >> 1;
      else             res[4*i +: 4] = f;
    end
    return res;
  endfunction

endpackage

// File: rtl/lru_victim_pick.sv
// Combinational victim choice for one set: first invalid way if any,
// otherwise the single way holding the LRU rank.
module lru_victim_pick
  import lru_pkg::*;
(
  input  logic [15:0] state,
  input  logic [3:0]  mask,
  output logic [3:0]  way,
  output logic        was_invalid,
  output logic        err
);

  logic [3:0] lru_hit;

  // Flag which ways currently hold the LRU rank.
  always_comb begin
    lru_hit = '0;
    for (int i = 0; i < WAYS; i++) begin
      lru_hit[i] = (state[4*i +: 4] == RANK_LRU);
    end
  end

  // Invalid ways win; a corrupt rank set falls back to way0 and flags err.
  always_comb begin
    way         = 4'b0001;
    was_invalid = 1'b0;
    err         = 1'b0;
    if (mask != 4'b1111) begin
      was_invalid = 1'b1;
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (!mask[i]) begin
          way    = '0;
          way[i] = 1'b1;
        end
      end
    end else if ($onehot(lru_hit)) begin
      way = lru_hit;
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/lru_victim_select.sv
// Per-set LRU state array with hit promotion and a two-state victim
// request/response FSM.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// req_ready is high only in IDLE, resp_valid only in RESP, and the
// response fields hold steady until resp_ready is seen.
module lru_victim_select
  import lru_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int SET_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit_valid,
  input  logic [SET_BITS-1:0] hit_set,
  input  logic [3:0]          hit_way,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [3:0]          req_way_valid,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [3:0]          resp_way,
  output logic                resp_was_invalid,
  output logic                lru_err
);

  logic [NUM_SETS-1:0][15:0] lru_q;
  logic [NUM_SETS-1:0][15:0] lru_d;
  logic [15:0]               set_tmp;

  fsm_state_e          state_q;
  fsm_state_e          state_d;
  logic [SET_BITS-1:0] set_q;
  logic [3:0]          resp_way_q;
  logic                resp_inv_q;
  logic                lru_err_q;
  logic                accept;
  logic                commit;
  logic [3:0]          pick_way;
  logic                pick_inv;
  logic                pick_err;

  // Victim is chosen from the pre-hit state of the requested set.
  lru_victim_pick u_pick (
    .state       (lru_q[req_set]),
    .mask        (req_way_valid),
    .way         (pick_way),
    .was_invalid (pick_inv),
    .err         (pick_err)
  );

  // Next-state and handshake outputs of the request FSM.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        commit     = resp_ready;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latch the victim at accept; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q      <= '0;
      resp_way_q <= '0;
      resp_inv_q <= 1'b0;
      lru_err_q  <= 1'b0;
    end else if (accept) begin
      set_q      <= req_set;
      resp_way_q <= pick_way;
      resp_inv_q <= pick_inv;
      if (pick_err) lru_err_q <= 1'b1;
    end
  end

  // Per-set update: hit promotion first, then victim commit on top of it.
  always_comb begin
    set_tmp = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      set_tmp = lru_q[s];
      if (hit_valid && (hit_set == SET_BITS'(s)))
        set_tmp = lru_promote(set_tmp, hit_way);
      if (commit && (set_q == SET_BITS'(s)))
        set_tmp = lru_promote(set_tmp, resp_way_q);
      lru_d[s] = set_tmp;
    end
  end

  // LRU state array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lru_q <= {NUM_SETS{LRU_RESET}};
    else        lru_q <= lru_d;
  end

  assign resp_way         = resp_way_q;
  assign resp_was_invalid = resp_inv_q;
  assign lru_err          = lru_err_q;

endmodule

// File: tb/tb_lru_victim_select.sv
module tb_lru_victim_select;

  localparam int NUM_SETS = 64;
  localparam int SET_BITS = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                hit_valid;
  logic [SET_BITS-1:0] hit_set;
  logic [3:0]          hit_way;
  logic                req_valid;
  logic                req_ready;
  logic [SET_BITS-1:0] req_set;
  logic [3:0]          req_way_valid;
  logic                resp_valid;
  logic                resp_ready;
  logic [3:0]          resp_way;
  logic                resp_was_invalid;
  logic                lru_err;

  lru_victim_select #(.NUM_SETS(NUM_SETS), .SET_BITS(SET_BITS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hit_valid        (hit_valid),
    .hit_set          (hit_set),
    .hit_way          (hit_way),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_set          (req_set),
    .req_way_valid    (req_way_valid),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_way         (resp_way),
    .resp_was_invalid (resp_was_invalid),
    .lru_err          (lru_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: recency order per set, index 0 = most recent way
  int unsigned ord[NUM_SETS][4];
  bit          exp_busy;
  int          exp_set;
  logic [3:0]  exp_way;
  logic        exp_inv;
  logic        exp_err;

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++)
      for (int p = 0; p < 4; p++) ord[s][p] = 3 - p;
    exp_busy = 0;
    exp_set  = 0;
    exp_way  = 4'b0000;
    exp_inv  = 1'b0;
    exp_err  = 1'b0;
  endtask

  function automatic int way_idx(input logic [3:0] w);
    case (w)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_touch(input int s, input int w);
    int p;
    p = 0;
    for (int k = 0; k < 4; k++) if (ord[s][k] == w) p = k;
    for (int k = p; k > 0; k--) ord[s][k] = ord[s][k-1];
    ord[s][0] = w;
  endtask

  function automatic logic [15:0] model_enc(input int s);
    logic [15:0] res;
    logic [3:0]  r4;
    res = '0;
    for (int p = 0; p < 4; p++) begin
      r4 = 4'b1000;
      r4 = r4 >> p;
      res[4*ord[s][p] +: 4] = r4;
    end
    return res;
  endfunction

  // driver: advance one clock, updating the model with the inputs in force
  task automatic step();
    bit acc;
    bit com;
    int z;
    acc = !exp_busy && req_valid;
    com = exp_busy && resp_ready;
    if (acc) begin
      if (req_way_valid != 4'hf) begin
        z = 0;
        for (int i = 3; i >= 0; i--) if (!req_way_valid[i]) z = i;
        exp_way = 4'(1 << z);
        exp_inv = 1'b1;
      end else begin
        exp_way = 4'(1 << ord[req_set][3]);
        exp_inv = 1'b0;
      end
      exp_set = int'(req_set);
    end
    if (hit_valid) model_touch(int'(hit_set), way_idx(hit_way));
    if (com) model_touch(exp_set, way_idx(exp_way));
    if (acc) exp_busy = 1;
    else if (com) exp_busy = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(exp_busy));
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(!exp_busy));
    if (exp_busy) begin
      chk({tag, "_resp_way"}, 32'(resp_way), 32'(exp_way));
      chk({tag, "_resp_inv"}, 32'(resp_was_invalid), 32'(exp_inv));
    end
    chk({tag, "_lru_err"}, 32'(lru_err), 32'(exp_err));
  endtask

  task automatic check_state(input string tag, input int s);
    chk(tag, 32'(dut.lru_q[s]), 32'(model_enc(s)));
  endtask

  task automatic clear_inputs();
    hit_valid = 0; hit_set = '0; hit_way = '0;
    req_valid = 0; req_set = '0; req_way_valid = '0;
    resp_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_request(input int s, input logic [3:0] mask, input string tag);
    req_valid = 1; req_set = SET_BITS'(s); req_way_valid = mask;
    step();
    req_valid = 0;
    check_outputs(tag);
  endtask

  task automatic do_commit(input string tag);
    resp_ready = 1;
    step();
    resp_ready = 0;
    check_outputs(tag);
  endtask

  typedef struct {
    int          set;
    logic [3:0]  mask;
    logic [3:0]  exp_way;
    logic        exp_inv;
    logic [15:0] exp_state;
  } vec_t;

  vec_t vecs[7];
  logic [NUM_SETS-1:0][15:0] forced_v;
  logic [15:0] tmp16;

  initial begin
    vecs[0] = '{5,  4'b1111, 4'b0001, 1'b0, 16'h4218};
    vecs[1] = '{5,  4'b1111, 4'b0010, 1'b0, 16'h2184};
    vecs[2] = '{9,  4'b1011, 4'b0100, 1'b1, 16'h4821};
    vecs[3] = '{10, 4'b0000, 4'b0001, 1'b1, 16'h4218};
    vecs[4] = '{11, 4'b1110, 4'b0001, 1'b1, 16'h4218};
    vecs[5] = '{12, 4'b0111, 4'b1000, 1'b1, 16'h8421};
    vecs[6] = '{5,  4'b1111, 4'b0100, 1'b0, 16'h1842};

    do_reset();
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_way", 32'(resp_way), 32'd0);
    chk("rst_resp_inv", 32'(resp_was_invalid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_lru_err", 32'(lru_err), 32'd0);
    chk("rst_set0", 32'(dut.lru_q[0]), 32'h8421);
    chk("rst_set63", 32'(dut.lru_q[63]), 32'h8421);

    // table-driven request/accept vectors
    for (int i = 0; i < 7; i++) begin
      do_request(vecs[i].set, vecs[i].mask, "tbl_req");
      chk("tbl_way", 32'(resp_way), 32'(vecs[i].exp_way));
      chk("tbl_inv", 32'(resp_was_invalid), 32'(vecs[i].exp_inv));
      do_commit("tbl_commit");
      chk("tbl_state", 32'(dut.lru_q[vecs[i].set]), 32'(vecs[i].exp_state));
      check_state("tbl_model_state", vecs[i].set);
    end

    // hit before request, then hits on the latched set while stalled
    hit_valid = 1; hit_set = 6'd3; hit_way = 4'b0001;
    step();
    hit_valid = 0;
    do_request(3, 4'b1111, "s3_req");
    chk("s3_way", 32'(resp_way), 32'b0010);
    for (int i = 0; i < 5; i++) begin
      hit_valid = 1; hit_set = 6'd3; hit_way = 4'b0010;
      step();
      chk("s3_hold_way", 32'(resp_way), 32'b0010);
      chk("s3_hold_ready", 32'(req_ready), 32'd0);
    end
    hit_valid = 0;
    do_commit("s3_commit");
    tmp16 = dut.lru_q[3];
    chk("s3_way1_mru", 32'(tmp16[7:4]), 32'b1000);
    check_state("s3_state", 3);

    // hit and victim commit on the same set in the same cycle
    do_request(2, 4'b1111, "s2_req");
    chk("s2_way", 32'(resp_way), 32'b0001);
    hit_valid = 1; hit_set = 6'd2; hit_way = 4'b1000;
    do_commit("s2_commit");
    hit_valid = 0;
    chk("s2_state", 32'(dut.lru_q[2]), 32'h4218);
    check_state("s2_model_state", 2);

    // randomized traffic on a few sets to force collisions
    for (int c = 0; c < 600; c++) begin
      hit_valid     = 1'($urandom_range(0, 1));
      hit_set       = SET_BITS'($urandom_range(0, 3));
      hit_way       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'(1 << $urandom_range(0, 3));
      req_valid     = 1'($urandom_range(0, 1));
      req_set       = SET_BITS'($urandom_range(0, 3));
      req_way_valid = ($urandom_range(0, 1) == 1) ? 4'hf : 4'($urandom_range(0, 15));
      resp_ready    = 1'($urandom_range(0, 1));
      step();
      check_outputs("rnd");
    end
    clear_inputs();
    for (int s = 0; s < 8; s++) check_state("rnd_state", s);

    // corrupt rank set: sticky error
    do_reset();
    forced_v = {NUM_SETS{16'h8421}};
    forced_v[7] = 16'h8422;
    force dut.lru_q = forced_v;
    req_valid = 1; req_set = 6'd7; req_way_valid = 4'hf;
    step();
    req_valid = 0;
    exp_err = 1'b1;
    chk("err_way", 32'(resp_way), 32'b0001);
    chk("err_flag", 32'(lru_err), 32'd1);
    do_commit("err_commit");
    release dut.lru_q;
    do_request(0, 4'hf, "err_clean_req");
    do_commit("err_clean_commit");
    chk("err_sticky", 32'(lru_err), 32'd1);

    // reset in the middle of a pending response
    do_request(1, 4'hf, "mid_req");
    #2 rst_n = 0;
    #1;
    chk("mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_resp_way", 32'(resp_way), 32'd0);
    chk("mid_lru_err", 32'(lru_err), 32'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    for (int s = 0; s < NUM_SETS; s++) chk("post_rst_set", 32'(dut.lru_q[s]), 32'h8421);
    do_request(7, 4'hf, "post_rst_req");
    chk("post_rst_way", 32'(resp_way), 32'b0001);
    do_commit("post_rst_commit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
